// File: rtl/rv_trace_pkg.sv
// Shared types for the pipeline trace recorder: FSM states, trigger modes,
// and the packed entry layout {pc, instr, exc, code, idex_valid, exmem_valid}.
package rv_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_EXC    = 2'b00;
  localparam logic [1:0] TRIG_PC     = 2'b01;
  localparam logic [1:0] TRIG_MANUAL = 2'b10;
  localparam logic [1:0] TRIG_ANY    = 2'b11;

  // Widest supported fields; actual widths are passed to the helpers below.
  localparam int MAX_XLEN    = 64;
  localparam int MAX_CODE_W  = 8;
  localparam int MAX_ENTRY_W = MAX_XLEN + 32 + MAX_CODE_W + 3;

  localparam int EXMEM_LSB = 0;
  localparam int IDEX_LSB  = 1;
  localparam int CODE_LSB  = 2;

  typedef logic [MAX_ENTRY_W-1:0] entry_raw_t;

  typedef struct packed {
    logic [MAX_XLEN-1:0]   pc;
    logic [31:0]           instr;
    logic                  exc;
    logic [MAX_CODE_W-1:0] code;
    logic                  idex_valid;
    logic                  exmem_valid;
  } trace_entry_t;

  function automatic int exc_lsb(input int code_w);
    return CODE_LSB + code_w;
  endfunction

  function automatic int instr_lsb(input int code_w);
    return CODE_LSB + code_w + 1;
  endfunction

  function automatic int pc_lsb(input int code_w);
    return CODE_LSB + code_w + 33;
  endfunction

  function automatic entry_raw_t field_mask(input int w);
    return {MAX_ENTRY_W{1'b1}} >> (MAX_ENTRY_W - w);
  endfunction

  function automatic entry_raw_t pack_entry(input trace_entry_t e, input int xlen,
                                            input int code_w);
    return ((entry_raw_t'(e.pc) & field_mask(xlen)) << pc_lsb(code_w))
         | (entry_raw_t'(e.instr) << instr_lsb(code_w))
         | (entry_raw_t'(e.exc) << exc_lsb(code_w))
         | ((entry_raw_t'(e.code) & field_mask(code_w)) << CODE_LSB)
         | (entry_raw_t'(e.idex_valid) << IDEX_LSB)
         | entry_raw_t'(e.exmem_valid);
  endfunction

  function automatic trace_entry_t unpack_entry(input entry_raw_t raw, input int xlen,
                                                input int code_w);
    trace_entry_t e;
    e.pc          = MAX_XLEN'((raw >> pc_lsb(code_w)) & field_mask(xlen));
    e.instr       = 32'(raw >> instr_lsb(code_w));
    e.exc         = 1'(raw >> exc_lsb(code_w));
    e.code        = MAX_CODE_W'((raw >> CODE_LSB) & field_mask(code_w));
    e.idex_valid  = 1'(raw >> IDEX_LSB);
    e.exmem_valid = 1'(raw);
    return e;
  endfunction

endpackage

// File: rtl/rv_trace_buffer_ram.sv
// Trace storage: register array with one synchronous write port and one
// combinational read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 71
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left unreset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_trace_buffer.sv
// Pipeline trace recorder: circular capture, trigger with post-trigger window,
// then oldest-first drain over a valid/ready stream.
module rv_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CODE_W  = 4,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int ENTRY_W = XLEN + 32 + CODE_W + 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [XLEN-1:0]    trig_pc,
  input  logic               trig_force,
  input  logic [AW-1:0]      post_count,
  input  logic               smp_en,
  input  logic [XLEN-1:0]    smp_pc,
  input  logic [31:0]        smp_instr,
  input  logic               smp_exc,
  input  logic [CODE_W-1:0]  smp_code,
  input  logic               smp_idex_valid,
  input  logic               smp_exmem_valid,
  output logic [1:0]         state,
  output logic               triggered,
  output logic [AW:0]        count,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  trace_state_e state_q, state_d;
  logic [AW-1:0] wptr_q, post_left_q, rptr, raddr;
  logic [AW:0]   count_q, rd_cnt_q;
  logic          triggered_q, force_pend_q;
  logic          trig_hit, fire, we, rd_fire;
  trace_entry_t  cur_entry;
  logic [ENTRY_W-1:0] wr_data, ram_rdata;

  always_comb begin
    cur_entry             = '0;
    cur_entry.pc          = MAX_XLEN'(smp_pc);
    cur_entry.instr       = smp_instr;
    cur_entry.exc         = smp_exc;
    cur_entry.code        = MAX_CODE_W'(smp_code);
    cur_entry.idex_valid  = smp_idex_valid;
    cur_entry.exmem_valid = smp_exmem_valid;
  end

  assign wr_data = ENTRY_W'(pack_entry(cur_entry, XLEN, CODE_W));

  // Oldest entry sits count slots behind the write pointer.
  assign rptr     = wptr_q - count_q[AW-1:0];
  assign raddr    = rptr + rd_cnt_q[AW-1:0];
  assign rd_valid = (state_q == ST_DONE) && (rd_cnt_q < count_q);
  assign rd_last  = rd_valid && (rd_cnt_q == count_q - (AW+1)'(1));
  assign rd_data  = rd_valid ? ram_rdata : '0;
  assign rd_fire  = rd_valid && rd_ready;

  assign we = smp_en && !arm && !reset && (state_q == ST_ARMED || state_q == ST_POST);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_EXC:    trig_hit = smp_exc;
      TRIG_PC:     trig_hit = (smp_pc == trig_pc);
      TRIG_MANUAL: trig_hit = force_pend_q || trig_force;
      default:     trig_hit = smp_exc || (smp_pc == trig_pc) || force_pend_q || trig_force;
    endcase
    fire = smp_en && (state_q == ST_ARMED) && trig_hit;

    state_d = state_q;
    case (state_q)
      ST_ARMED: if (fire) state_d = (post_count == '0) ? ST_DONE : ST_POST;
      ST_POST:  if (smp_en && post_left_q == AW'(1)) state_d = ST_DONE;
      ST_DONE:  if (rd_fire && rd_last) state_d = ST_IDLE;
      default:  state_d = state_q;
    endcase
    if (arm) state_d = ST_ARMED;
  end

  // NOTE: registers update with non-blocking assignments so all see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      wptr_q       <= '0;
      count_q      <= '0;
      rd_cnt_q     <= '0;
      post_left_q  <= '0;
      triggered_q  <= 1'b0;
      force_pend_q <= 1'b0;
    end else begin
      if (we) begin
        wptr_q <= wptr_q + AW'(1);
        if (count_q != DEPTH_CNT) count_q <= count_q + (AW+1)'(1);
      end
      // A pending manual request survives stalls; any qualified sample consumes it.
      if (state_q == ST_ARMED) begin
        if (smp_en)          force_pend_q <= 1'b0;
        else if (trig_force) force_pend_q <= 1'b1;
      end
      if (fire) begin
        triggered_q <= 1'b1;
        post_left_q <= post_count;
      end else if (state_q == ST_POST && smp_en) begin
        post_left_q <= post_left_q - AW'(1);
      end
      if (rd_fire) rd_cnt_q <= rd_cnt_q + (AW+1)'(1);
    end
  end

  trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  assign state     = state_q;
  assign triggered = triggered_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Directed bench for rv_trace_buffer (DEPTH=8): vector table plus hand-written
// multi-cycle sequences for wrap, stalls, backpressure, arm and reset mid-flight.
module tb_rv_trace_buffer;
  import rv_trace_pkg::*;

  localparam int XLEN    = 32;
  localparam int CODE_W  = 4;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int ENTRY_W = XLEN + 32 + CODE_W + 3;
  localparam logic [31:0] NO_EXC = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               reset, arm, trig_force, smp_en, smp_exc;
  logic               smp_idex_valid, smp_exmem_valid, rd_ready;
  logic [1:0]         trig_mode;
  logic [XLEN-1:0]    trig_pc, smp_pc;
  logic [AW-1:0]      post_count;
  logic [31:0]        smp_instr;
  logic [CODE_W-1:0]  smp_code;
  logic [1:0]         state;
  logic               triggered, rd_valid, rd_last;
  logic [AW:0]        count;
  logic [ENTRY_W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        arm;
    logic        en;
    logic [31:0] pc;
    logic        ready;
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic        trig;
    logic        vld;
    logic        last;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs [11];

  rv_trace_buffer #(.XLEN(XLEN), .CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .arm             (arm),
    .trig_mode       (trig_mode),
    .trig_pc         (trig_pc),
    .trig_force      (trig_force),
    .post_count      (post_count),
    .smp_en          (smp_en),
    .smp_pc          (smp_pc),
    .smp_instr       (smp_instr),
    .smp_exc         (smp_exc),
    .smp_code        (smp_code),
    .smp_idex_valid  (smp_idex_valid),
    .smp_exmem_valid (smp_exmem_valid),
    .state           (state),
    .triggered       (triggered),
    .count           (count),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .rd_last         (rd_last)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every sample's other fields are derived from its PC so entries are self-describing.
  task automatic set_smp(input logic en, input logic [31:0] pc, input logic exc);
    smp_en          = en;
    smp_pc          = pc;
    smp_instr       = ~pc;
    smp_exc         = exc;
    smp_code        = pc[5:2];
    smp_idex_valid  = 1'b1;
    smp_exmem_valid = pc[2];
  endtask

  function automatic logic [ENTRY_W-1:0] exp_entry(input logic [31:0] pc, input logic exc);
    logic [31:0] ipc;
    ipc = ~pc;
    return {pc, ipc, exc, pc[5:2], 1'b1, pc[2]};
  endfunction

  task automatic pulse_arm();
    arm = 1'b1;
    set_smp(1'b0, 32'h0, 1'b0);
    step();
    arm = 1'b0;
  endtask

  task automatic readout(input string tag, input int n, input logic [31:0] base,
                         input logic [31:0] exc_pc);
    for (int k = 0; k < n; k++) begin
      logic [31:0] pc;
      pc = base + 32'(4 * k);
      check({tag, "_valid"}, 128'(rd_valid), 128'(1'b1));
      check({tag, "_data"}, 128'(rd_data), 128'(exp_entry(pc, pc == exc_pc)));
      check({tag, "_last"}, 128'(rd_last), 128'(k == n - 1));
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    check({tag, "_end_state"}, 128'(state), 128'(ST_IDLE));
    check({tag, "_end_valid"}, 128'(rd_valid), 128'(1'b0));
  endtask

  initial begin
    int          k;
    logic        stalled_prev;
    logic [ENTRY_W-1:0] prev_data;

    //                arm   en    pc      rdy   st    cnt   trig  vld   last  rpc
    vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h08, 1'b0, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 2'd1, 4'd4, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[5]  = '{1'b0, 1'b1, 32'h10, 1'b0, 2'd3, 4'd5, 1'b1, 1'b1, 1'b0, 32'h00};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 4'd5, 1'b1, 1'b1, 1'b0, 32'h04};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 4'd5, 1'b1, 1'b1, 1'b0, 32'h08};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 4'd5, 1'b1, 1'b1, 1'b0, 32'h0C};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 4'd5, 1'b1, 1'b1, 1'b1, 32'h10};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 4'd5, 1'b1, 1'b0, 1'b0, 32'h00};

    reset      = 1'b1;
    arm        = 1'b0;
    trig_mode  = TRIG_EXC;
    trig_pc    = 32'h0;
    trig_force = 1'b0;
    post_count = '0;
    rd_ready   = 1'b0;
    set_smp(1'b0, 32'h0, 1'b0);

    // Reset held two cycles, then released.
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_state", 128'(state), 128'(ST_IDLE));
    check("rst_valid", 128'(rd_valid), 128'(1'b0));
    check("rst_trig", 128'(triggered), 128'(1'b0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_data", 128'(rd_data), 128'(0));
    check("rst_last", 128'(rd_last), 128'(1'b0));

    // Exception trigger at pc 0x28, two post samples, buffer wraps.
    trig_mode  = TRIG_EXC;
    post_count = 3'd2;
    pulse_arm();
    for (int i = 0; i < 20; i++) begin
      set_smp(1'b1, 32'(4 * i), i == 10);
      step();
      if (i == 10) check("t2_post", 128'(state), 128'(ST_POST));
      if (i == 11) check("t2_still_post", 128'(state), 128'(ST_POST));
      if (i == 12) check("t2_done", 128'(state), 128'(ST_DONE));
    end
    set_smp(1'b0, 32'h0, 1'b0);
    check("t2_count", 128'(count), 128'(8));
    check("t2_trig", 128'(triggered), 128'(1'b1));
    readout("t2_rd", 8, 32'h14, 32'h28);

    // PC-match trigger, post_count=0, cycle-by-cycle table.
    trig_mode  = TRIG_PC;
    trig_pc    = 32'h10;
    post_count = 3'd0;
    for (int r = 0; r < 11; r++) begin
      arm      = vecs[r].arm;
      set_smp(vecs[r].en, vecs[r].pc, 1'b0);
      rd_ready = vecs[r].ready;
      step();
      check($sformatf("tv%0d_state", r), 128'(state), 128'(vecs[r].st));
      check($sformatf("tv%0d_count", r), 128'(count), 128'(vecs[r].cnt));
      check($sformatf("tv%0d_trig", r), 128'(triggered), 128'(vecs[r].trig));
      check($sformatf("tv%0d_valid", r), 128'(rd_valid), 128'(vecs[r].vld));
      check($sformatf("tv%0d_last", r), 128'(rd_last), 128'(vecs[r].last));
      if (vecs[r].vld)
        check($sformatf("tv%0d_data", r), 128'(rd_data), 128'(exp_entry(vecs[r].rpc, 1'b0)));
    end
    arm      = 1'b0;
    rd_ready = 1'b0;

    // Manual trigger requested during a stall, consumed by the next qualified sample.
    trig_mode  = TRIG_MANUAL;
    post_count = 3'd2;
    pulse_arm();
    set_smp(1'b1, 32'h100, 1'b0); step();
    set_smp(1'b1, 32'h104, 1'b0); step();
    trig_force = 1'b1;
    set_smp(1'b0, 32'hDEAD0, 1'b0); step();
    trig_force = 1'b0;
    check("t4_force_state", 128'(state), 128'(ST_ARMED));
    check("t4_force_trig", 128'(triggered), 128'(1'b0));
    for (int s = 0; s < 3; s++) begin
      set_smp(1'b0, 32'hDEAD4 + 32'(4 * s), 1'b0);
      step();
    end
    check("t4_stall_state", 128'(state), 128'(ST_ARMED));
    check("t4_stall_trig", 128'(triggered), 128'(1'b0));
    check("t4_stall_count", 128'(count), 128'(2));
    set_smp(1'b1, 32'h108, 1'b0); step();
    check("t4_fire_state", 128'(state), 128'(ST_POST));
    check("t4_fire_trig", 128'(triggered), 128'(1'b1));
    set_smp(1'b0, 32'hDEAE0, 1'b0); step();
    set_smp(1'b0, 32'hDEAE4, 1'b0); step();
    check("t4_post_stall", 128'(state), 128'(ST_POST));
    set_smp(1'b1, 32'h10C, 1'b0); step();
    check("t4_post1", 128'(state), 128'(ST_POST));
    set_smp(1'b0, 32'hDEAE8, 1'b0); step();
    set_smp(1'b1, 32'h110, 1'b0); step();
    set_smp(1'b0, 32'h0, 1'b0);
    check("t4_done", 128'(state), 128'(ST_DONE));
    check("t4_count", 128'(count), 128'(5));
    readout("t4_rd", 5, 32'h100, NO_EXC);

    // Backpressured readout (ready 1,0,0,...), then arm mid-readout.
    trig_mode  = TRIG_PC;
    trig_pc    = 32'h210;
    post_count = 3'd3;
    pulse_arm();
    for (int i = 0; i < 10; i++) begin
      set_smp(1'b1, 32'h200 + 32'(4 * i), 1'b0);
      step();
    end
    set_smp(1'b0, 32'h0, 1'b0);
    check("t5_done", 128'(state), 128'(ST_DONE));
    check("t5_count", 128'(count), 128'(8));
    k = 0;
    stalled_prev = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 30 && k < 5; c++) begin
      check("t5_valid", 128'(rd_valid), 128'(1'b1));
      check("t5_data", 128'(rd_data), 128'(exp_entry(32'h200 + 32'(4 * k), 1'b0)));
      check("t5_last", 128'(rd_last), 128'(1'b0));
      if (stalled_prev) check("t5_stable", 128'(rd_data), 128'(prev_data));
      prev_data    = rd_data;
      rd_ready     = (c % 3 == 0);
      stalled_prev = !rd_ready;
      step();
      if (rd_ready) k++;
    end
    rd_ready = 1'b0;
    check("t5_delivered", 128'(k), 128'(5));
    pulse_arm();
    check("t5_arm_valid", 128'(rd_valid), 128'(1'b0));
    check("t5_arm_state", 128'(state), 128'(ST_ARMED));
    check("t5_arm_count", 128'(count), 128'(0));
    check("t5_arm_trig", 128'(triggered), 128'(1'b0));

    // Reset during POST with three post samples still owed.
    trig_mode  = TRIG_EXC;
    post_count = 3'd5;
    pulse_arm();
    set_smp(1'b1, 32'h300, 1'b1); step();
    set_smp(1'b1, 32'h304, 1'b0); step();
    set_smp(1'b1, 32'h308, 1'b0); step();
    check("t6_post", 128'(state), 128'(ST_POST));
    check("t6_pre_count", 128'(count), 128'(3));
    reset = 1'b1;
    set_smp(1'b1, 32'h30C, 1'b1);
    step();
    reset = 1'b0;
    set_smp(1'b0, 32'h0, 1'b0);
    check("t6_rst_state", 128'(state), 128'(ST_IDLE));
    check("t6_rst_count", 128'(count), 128'(0));
    check("t6_rst_trig", 128'(triggered), 128'(1'b0));
    check("t6_rst_valid", 128'(rd_valid), 128'(1'b0));
    trig_mode  = TRIG_PC;
    trig_pc    = 32'h404;
    post_count = 3'd0;
    pulse_arm();
    set_smp(1'b1, 32'h400, 1'b0); step();
    set_smp(1'b1, 32'h404, 1'b0); step();
    set_smp(1'b0, 32'h0, 1'b0);
    check("t6_done", 128'(state), 128'(ST_DONE));
    check("t6_count", 128'(count), 128'(2));
    check("t6_trig", 128'(triggered), 128'(1'b1));
    readout("t6_rd", 2, 32'h400, NO_EXC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
